// File: rtl/operand_forward_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : operand_forward_buffer_pkg                                       |
// | Brief   : Shared constants for the operand forward buffer: the "value      |
// |           ready" ROB tag and the default tag / data widths.                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package operand_forward_buffer_pkg;

    // Tag value meaning "no producer outstanding, the value is ready"
    localparam int ZERO_ROB      = 0;

    // Default widths reused as the ROB_ID_W / DATA_W parameter defaults
    localparam int ROB_ID_TYPE_W = 4;
    localparam int DATA_TYPE_W   = 32;

    typedef logic [ROB_ID_TYPE_W-1:0] rob_id_t;
    typedef logic [DATA_TYPE_W-1:0]   data_t;

endpackage
`default_nettype wire

// File: rtl/operand_forward_buffer_cdb_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : opfwd_cdb_match                                                  |
// | Brief   : Combinational priority match of one tag against NUM_CDB live     |
// |           CDB channels. The lowest-numbered matching channel wins.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module opfwd_cdb_match
    import operand_forward_buffer_pkg::*;
#(
    parameter int NUM_CDB  = 2,
    parameter int ROB_ID_W = ROB_ID_TYPE_W,
    parameter int DATA_W   = DATA_TYPE_W
) (
    input  logic [ROB_ID_W-1:0]         tag,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    output logic                        hit,
    output logic [DATA_W-1:0]           value
);

    // Walk channels high to low so the lowest matching channel is the last write
    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_rob_id[k*ROB_ID_W +: ROB_ID_W] == tag)) begin
                hit   = 1'b1;
                value = cdb_result[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_forward_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : operand_forward_buffer                                           |
// | Brief   : Registered operand-resolution stage. Resolves both source        |
// |           operands from live CDBs, recent CDB history, the ROB and the     |
// |           register file, holds them under valid/ready and keeps snooping  |
// |           the CDBs while the output is stalled.                            |
// | Config  : OPFWD_HISTORY_EN - builds the CDB history buffer and the         |
// |           alloc-time tag invalidation. Undefined: live CDB/ROB/regfile.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module operand_forward_buffer
    import operand_forward_buffer_pkg::*;
#(
    parameter int NUM_CDB    = 2,
    parameter int HIST_DEPTH = 4,
    parameter int ROB_ID_W   = ROB_ID_TYPE_W,
    parameter int DATA_W     = DATA_TYPE_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    input  logic                        alloc_valid,
    input  logic [ROB_ID_W-1:0]         alloc_rob_id,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [ROB_ID_W-1:0]         q1_from_reg,
    input  logic [ROB_ID_W-1:0]         q2_from_reg,
    input  logic [DATA_W-1:0]           v1_from_reg,
    input  logic [DATA_W-1:0]           v2_from_reg,
    input  logic                        q1_ready_from_rob,
    input  logic                        q2_ready_from_rob,
    input  logic [DATA_W-1:0]           v1_result_from_rob,
    input  logic [DATA_W-1:0]           v2_result_from_rob,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROB_ID_W-1:0]         q1_to_dispatch,
    output logic [ROB_ID_W-1:0]         q2_to_dispatch,
    output logic [DATA_W-1:0]           v1_to_dispatch,
    output logic [DATA_W-1:0]           v2_to_dispatch
);

    localparam logic [ROB_ID_W-1:0] ZERO_TAG = ROB_ID_W'(ZERO_ROB);

    // Per-operand views of the request, index 0 = operand 1, index 1 = operand 2
    logic [1:0][ROB_ID_W-1:0] req_tag;
    logic [1:0][DATA_W-1:0]   req_v;
    logic [1:0]               rob_rdy;
    logic [1:0][DATA_W-1:0]   rob_v;

    // Lookup results
    logic [1:0]               live_hit;
    logic [1:0][DATA_W-1:0]   live_val;
    logic [1:0]               hist_hit;
    logic [1:0][DATA_W-1:0]   hist_val;
    logic [1:0]               snoop_hit;
    logic [1:0][DATA_W-1:0]   snoop_val;
    logic [1:0][ROB_ID_W-1:0] res_q;
    logic [1:0][DATA_W-1:0]   res_v;

    // Output register
    logic [1:0][ROB_ID_W-1:0] out_q;
    logic [1:0][DATA_W-1:0]   out_v;

    logic                     accept;

    assign req_tag[0] = q1_from_reg;
    assign req_tag[1] = q2_from_reg;
    assign req_v[0]   = v1_from_reg;
    assign req_v[1]   = v2_from_reg;
    assign rob_rdy[0] = q1_ready_from_rob;
    assign rob_rdy[1] = q2_ready_from_rob;
    assign rob_v[0]   = v1_result_from_rob;
    assign rob_v[1]   = v2_result_from_rob;

    // rst_n is folded in so nothing is accepted while reset is asserted
    assign issue_ready = rst_n & rdy & ~flush & (~out_valid | out_ready);
    assign accept      = issue_valid & issue_ready;

    generate
        for (genvar o = 0; o < 2; o++) begin : g_op
            // Issue-time match of the requested tag against the live CDBs
            opfwd_cdb_match #(
                .NUM_CDB  (NUM_CDB),
                .ROB_ID_W (ROB_ID_W),
                .DATA_W   (DATA_W)
            ) u_issue_match (
                .tag        (req_tag[o]),
                .cdb_valid  (cdb_valid),
                .cdb_rob_id (cdb_rob_id),
                .cdb_result (cdb_result),
                .hit        (live_hit[o]),
                .value      (live_val[o])
            );

            // Hold-time match of the held tag against the live CDBs
            opfwd_cdb_match #(
                .NUM_CDB  (NUM_CDB),
                .ROB_ID_W (ROB_ID_W),
                .DATA_W   (DATA_W)
            ) u_snoop_match (
                .tag        (out_q[o]),
                .cdb_valid  (cdb_valid),
                .cdb_rob_id (cdb_rob_id),
                .cdb_result (cdb_result),
                .hit        (snoop_hit[o]),
                .value      (snoop_val[o])
            );

            // Priority: ready tag, live CDB, history, ROB, then keep the tag
            assign res_q[o] = ((req_tag[o] == ZERO_TAG) || live_hit[o] ||
                               hist_hit[o] || rob_rdy[o]) ? ZERO_TAG : req_tag[o];
            assign res_v[o] = (req_tag[o] == ZERO_TAG) ? req_v[o]    :
                              live_hit[o]              ? live_val[o] :
                              hist_hit[o]              ? hist_val[o] :
                              rob_rdy[o]               ? rob_v[o]    :
                                                         req_v[o];
        end
    endgenerate

`ifdef OPFWD_HISTORY_EN
    localparam int PTR_W = $clog2(HIST_DEPTH);

    logic [NUM_CDB-1:0]               hist_valid [HIST_DEPTH];
    logic [NUM_CDB-1:0][ROB_ID_W-1:0] hist_tag   [HIST_DEPTH];
    logic [NUM_CDB-1:0][DATA_W-1:0]   hist_data  [HIST_DEPTH];
    logic [PTR_W-1:0]                 wptr;
    logic [PTR_W-1:0]                 row;

    // Search history newest row first (wptr-1 backwards), lower slot first
    always_comb begin
        hist_hit = '0;
        hist_val = '0;
        row      = '0;
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                row = wptr - PTR_W'(i + 1);
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (!hist_hit[o] && hist_valid[row][k] &&
                        (hist_tag[row][k] == req_tag[o])) begin
                        hist_hit[o] = 1'b1;
                        hist_val[o] = hist_data[row][k];
                    end
                end
            end
        end
    end

    // Record the live CDBs each enabled cycle; a reallocated tag is purged everywhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            for (int r = 0; r < HIST_DEPTH; r++) begin
                hist_valid[r] <= '0;
                hist_tag[r]   <= '0;
                hist_data[r]  <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                wptr <= '0;
                for (int r = 0; r < HIST_DEPTH; r++) begin
                    hist_valid[r] <= '0;
                end
            end else begin
                for (int r = 0; r < HIST_DEPTH; r++) begin
                    for (int k = 0; k < NUM_CDB; k++) begin
                        if (alloc_valid && (hist_tag[r][k] == alloc_rob_id)) begin
                            hist_valid[r][k] <= 1'b0;
                        end
                    end
                end
                // Row write comes last so it overrides the purge of the old row
                for (int k = 0; k < NUM_CDB; k++) begin
                    hist_valid[wptr][k] <= cdb_valid[k] &&
                        !(alloc_valid && (cdb_rob_id[k*ROB_ID_W +: ROB_ID_W] == alloc_rob_id));
                    hist_tag[wptr][k]   <= cdb_rob_id[k*ROB_ID_W +: ROB_ID_W];
                    hist_data[wptr][k]  <= cdb_result[k*DATA_W +: DATA_W];
                end
                wptr <= wptr + 1'b1;
            end
        end
    end
`else
    // No history storage: only live CDB, ROB and regfile resolve operands
    assign hist_hit = '0;
    assign hist_val = '0;

    localparam int unused_hist_depth = HIST_DEPTH;
    logic unused_alloc;
    assign unused_alloc = &{1'b0, alloc_valid, alloc_rob_id};
`endif

    // Output register: flush beats acceptance, acceptance beats hold snoop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_v     <= '0;
        end else if (rdy) begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_q     <= res_q;
                out_v     <= res_v;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else if (out_valid) begin
                for (int o = 0; o < 2; o++) begin
                    if ((out_q[o] != ZERO_TAG) && snoop_hit[o]) begin
                        out_q[o] <= ZERO_TAG;
                        out_v[o] <= snoop_val[o];
                    end
                end
            end
        end
    end

    assign q1_to_dispatch = out_q[0];
    assign q2_to_dispatch = out_q[1];
    assign v1_to_dispatch = out_v[0];
    assign v2_to_dispatch = out_v[1];

endmodule
`default_nettype wire

// File: tb/tb_operand_forward_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_operand_forward_buffer                                        |
// | Brief   : Scoreboard bench for operand_forward_buffer: a reference model   |
// |           predicts each accepted request and a monitor compares outputs.   |
// | Config  : follows OPFWD_HISTORY_EN like the design.                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_operand_forward_buffer;

    localparam int NC = 2;
    localparam int HD = 4;
    localparam int RW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n, rdy, flush;
    logic [NC-1:0]    cdb_valid;
    logic [NC*RW-1:0] cdb_rob_id;
    logic [NC*DW-1:0] cdb_result;
    logic             alloc_valid;
    logic [RW-1:0]    alloc_rob_id;
    logic             issue_valid, issue_ready;
    logic [RW-1:0]    q1_from_reg, q2_from_reg;
    logic [DW-1:0]    v1_from_reg, v2_from_reg;
    logic             q1_ready_from_rob, q2_ready_from_rob;
    logic [DW-1:0]    v1_result_from_rob, v2_result_from_rob;
    logic             out_valid, out_ready;
    logic [RW-1:0]    q1_to_dispatch, q2_to_dispatch;
    logic [DW-1:0]    v1_to_dispatch, v2_to_dispatch;

    operand_forward_buffer #(
        .NUM_CDB(NC), .HIST_DEPTH(HD), .ROB_ID_W(RW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
        .alloc_valid(alloc_valid), .alloc_rob_id(alloc_rob_id),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .q1_from_reg(q1_from_reg), .q2_from_reg(q2_from_reg),
        .v1_from_reg(v1_from_reg), .v2_from_reg(v2_from_reg),
        .q1_ready_from_rob(q1_ready_from_rob), .q2_ready_from_rob(q2_ready_from_rob),
        .v1_result_from_rob(v1_result_from_rob), .v2_result_from_rob(v2_result_from_rob),
        .out_valid(out_valid), .out_ready(out_ready),
        .q1_to_dispatch(q1_to_dispatch), .q2_to_dispatch(q2_to_dispatch),
        .v1_to_dispatch(v1_to_dispatch), .v2_to_dispatch(v2_to_dispatch)
    );

    always #5 clk = ~clk;

    typedef struct { logic [RW-1:0] q1; logic [DW-1:0] v1; logic [RW-1:0] q2; logic [DW-1:0] v2; } exp_t;
    typedef struct { logic [RW-1:0] tag; logic [DW-1:0] data; int n; } hent_t;

    exp_t  exp_q[$];
    hent_t hist[$];
    int    ncount = 0;
    int    total  = 0;
    int    bad    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference resolution: ready tag, live CDB (low channel first),
    // most recent broadcast among the last HD enabled cycles, ROB, regfile
    function automatic void resolve(input logic [RW-1:0] tag, input logic [DW-1:0] vr,
                                    input logic rr, input logic [DW-1:0] rv,
                                    output logic [RW-1:0] q, output logic [DW-1:0] v);
        int best;
        best = -1;
        q = tag;
        v = vr;
        if (tag == 0) return;
        for (int k = 0; k < NC; k++) begin
            if (cdb_valid[k] && cdb_rob_id[k*RW +: RW] == tag) begin
                q = 0;
                v = cdb_result[k*DW +: DW];
                return;
            end
        end
`ifdef OPFWD_HISTORY_EN
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].tag == tag && hist[i].n >= ncount - HD && hist[i].n > best) begin
                best = hist[i].n;
                v = hist[i].data;
            end
        end
        if (best >= 0) begin
            q = 0;
            return;
        end
`endif
        if (rr) begin
            q = 0;
            v = rv;
        end
    endfunction

    function automatic void live_snoop(inout logic [RW-1:0] q, inout logic [DW-1:0] v);
        if (q == 0) return;
        for (int k = 0; k < NC; k++) begin
            if (cdb_valid[k] && cdb_rob_id[k*RW +: RW] == q) begin
                q = 0;
                v = cdb_result[k*DW +: DW];
                return;
            end
        end
    endfunction

    // Monitor: compares presented outputs with the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("q1", 64'(q1_to_dispatch), 64'(exp_q[0].q1));
                    check("v1", 64'(v1_to_dispatch), 64'(exp_q[0].v1));
                    check("q2", 64'(q2_to_dispatch), 64'(exp_q[0].q2));
                    check("v2", 64'(v2_to_dispatch), 64'(exp_q[0].v2));
                    if (rdy && out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Model: predicts the effect of this cycle's inputs at the next edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                logic pred;
                pred = rdy && !flush && (exp_q.size() == 0);
                check("issue_ready", 64'(issue_ready), 64'(pred));
                if (rdy) begin
                    if (flush) begin
                        exp_q.delete();
                        hist.delete();
                    end else begin
                        if (issue_valid && pred) begin
                            resolve(q1_from_reg, v1_from_reg, q1_ready_from_rob, v1_result_from_rob, e.q1, e.v1);
                            resolve(q2_from_reg, v2_from_reg, q2_ready_from_rob, v2_result_from_rob, e.q2, e.v2);
                            exp_q.push_back(e);
                        end else if (exp_q.size() != 0) begin
                            e = exp_q[0];
                            live_snoop(e.q1, e.v1);
                            live_snoop(e.q2, e.v2);
                            exp_q[0] = e;
                        end
`ifdef OPFWD_HISTORY_EN
                        if (alloc_valid) begin
                            for (int i = hist.size() - 1; i >= 0; i--)
                                if (hist[i].tag == alloc_rob_id) hist.delete(i);
                        end
                        for (int k = 0; k < NC; k++) begin
                            if (cdb_valid[k] && !(alloc_valid && cdb_rob_id[k*RW +: RW] == alloc_rob_id))
                                hist.push_back('{cdb_rob_id[k*RW +: RW], cdb_result[k*DW +: DW], ncount});
                        end
                        ncount++;
                        for (int i = hist.size() - 1; i >= 0; i--)
                            if (hist[i].n < ncount - HD) hist.delete(i);
`endif
                    end
                end
            end
        end
    end

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
        cdb_valid = '0; cdb_rob_id = '0; cdb_result = '0;
        alloc_valid = 1'b0; alloc_rob_id = '0;
        issue_valid = 1'b0;
        q1_from_reg = '0; q2_from_reg = '0; v1_from_reg = '0; v2_from_reg = '0;
        q1_ready_from_rob = 1'b0; q2_ready_from_rob = 1'b0;
        v1_result_from_rob = '0; v2_result_from_rob = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [RW-1:0] q1, input logic [DW-1:0] v1,
                         input logic [RW-1:0] q2, input logic [DW-1:0] v2);
        issue_valid = 1'b1;
        q1_from_reg = q1; v1_from_reg = v1;
        q2_from_reg = q2; v2_from_reg = v2;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        issue_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst issue_ready", 64'(issue_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst outputs", {24'd0, q1_to_dispatch, q2_to_dispatch, v1_to_dispatch | v2_to_dispatch}, 64'd0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        // Plain pass-through of ready operands
        issue(4'd0, 32'd5, 4'd0, 32'd7); tick(); idle(); tick();

        // Both CDBs carry tag 3: channel 0 wins
        issue(4'd3, 32'h1, 4'd0, 32'h2);
        cdb_valid = 2'b11; cdb_rob_id = {4'd3, 4'd3}; cdb_result = {32'hBB, 32'hAA};
        tick(); idle(); tick();

        // Tag 6 on CDB1, consumed two cycles later via history (or kept)
        cdb_valid = 2'b10; cdb_rob_id = {4'd6, 4'd0}; cdb_result = {32'h1234, 32'h0};
        tick(); idle(); tick();
        issue(4'd0, 32'h9, 4'd6, 32'h55); tick(); idle(); tick();

        // Reallocation of tag 6 purges it from history
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd6}; cdb_result = {32'h0, 32'h77};
        tick(); idle();
        alloc_valid = 1'b1; alloc_rob_id = 4'd6;
        tick(); idle();
        issue(4'd6, 32'h11, 4'd0, 32'h22); tick(); idle(); tick();

        // Held output picks up tag 9 from CDB0 while stalled
        out_ready = 1'b0;
        issue(4'd0, 32'h1, 4'd9, 32'h3); tick();
        issue_valid = 1'b1; out_ready = 1'b0;
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_result = {32'h0, 32'h42};
        tick();
        cdb_valid = '0; tick();
        idle(); tick(); tick();

        // Flush beats a same-cycle issue and empties history
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd5}; cdb_result = {32'h0, 32'h5A};
        tick(); idle();
        flush = 1'b1; issue(4'd0, 32'h1, 4'd0, 32'h2);
        tick(); idle();
        issue(4'd5, 32'h66, 4'd0, 32'h3); tick(); idle(); tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rdy         = ($urandom % 8) != 0;
            flush       = ($urandom % 40) == 0;
            out_ready   = ($urandom % 3) != 0;
            issue_valid = ($urandom % 4) != 0;
            cdb_valid   = NC'($urandom);
            cdb_rob_id  = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 7))};
            cdb_result  = {$urandom, $urandom};
            alloc_valid = ($urandom % 4) == 0;
            alloc_rob_id = 4'($urandom_range(1, 7));
            q1_from_reg = 4'($urandom_range(0, 7));
            q2_from_reg = 4'($urandom_range(0, 7));
            v1_from_reg = $urandom; v2_from_reg = $urandom;
            q1_ready_from_rob = ($urandom % 4) == 0;
            q2_ready_from_rob = ($urandom % 4) == 0;
            v1_result_from_rob = $urandom; v2_result_from_rob = $urandom;
            tick();
        end

        idle();
        repeat (4) tick();
        @(negedge clk);
        check("drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
